// File: rtl/track_ctrl.sv
// Sequencer for manual positioning -> template capture -> tracking of the box/tracker datapath.
// Optional TRACK_SMOOTH_EN: accepted positions are averaged with the previous output.
//
// state   | meaning
// MANUAL  | box under user control, waiting for a start request edge
// ARM     | waiting for the next frame_start to begin capture
// CAPTURE | template RAM written for one full frame
// TRACK   | forwarding accepted matches, counting missed frames
module track_ctrl #(
  parameter logic [15:0] SCORE_MIN   = 16'd1000,
  parameter int          LOST_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_req,
  input  logic        cancel_req,
  input  logic        frame_start,
  input  logic        template_in_box,
  input  logic        max_ready,
  input  logic [15:0] max_score,
  input  logic [9:0]  max_x,
  input  logic [9:0]  max_y,
  output logic        tracking_mode,
  output logic        template_we,
  output logic        box_max_ready,
  output logic [9:0]  box_max_x,
  output logic [9:0]  box_max_y,
  output logic        capture_done,
  output logic        lost,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    MANUAL  = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    TRACK   = 2'd3
  } state_t;

  localparam logic [3:0] LOST_CNT = 4'(LOST_FRAMES);

  state_t     st;
  logic       start_q;
  logic       hit;
  logic [3:0] miss_cnt;
  logic [3:0] miss_next;
  logic       start_rise;
  logic       accept;
  logic [9:0] x_next;
  logic [9:0] y_next;

  assign state         = st;
  assign tracking_mode = (st == TRACK);
  assign template_we   = template_in_box && (st == CAPTURE);
  assign start_rise    = start_req && !start_q;
  assign accept        = max_ready && (max_score >= SCORE_MIN) && (st == TRACK) && !cancel_req;
  assign miss_next     = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;

`ifdef TRACK_SMOOTH_EN
  logic        first_res;
  logic [10:0] sum_x;
  logic [10:0] sum_y;

  assign sum_x  = {1'b0, box_max_x} + {1'b0, max_x} + 11'd1;
  assign sum_y  = {1'b0, box_max_y} + {1'b0, max_y} + 11'd1;
  assign x_next = first_res ? max_x : 10'(sum_x >> 1);
  assign y_next = first_res ? max_y : 10'(sum_y >> 1);

  // First accepted result after a fresh capture has no history to average with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      first_res <= 1'b0;
    else if (!cancel_req && st == CAPTURE && frame_start)
      first_res <= 1'b1;
    else if (accept)
      first_res <= 1'b0;
  end
`else
  assign x_next = max_x;
  assign y_next = max_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= MANUAL;
      start_q       <= 1'b0;
      hit           <= 1'b0;
      miss_cnt      <= 4'd0;
      capture_done  <= 1'b0;
      lost          <= 1'b0;
      box_max_ready <= 1'b0;
      box_max_x     <= 10'd0;
      box_max_y     <= 10'd0;
    end else begin
      start_q       <= start_req;
      capture_done  <= 1'b0;
      lost          <= 1'b0;
      box_max_ready <= 1'b0;
      if (cancel_req) begin
        st       <= MANUAL;
        hit      <= 1'b0;
        miss_cnt <= 4'd0;
      end else begin
        case (st)
          MANUAL:  if (start_rise) st <= ARM;
          ARM:     if (frame_start) st <= CAPTURE;
          CAPTURE: if (frame_start) begin
            st           <= TRACK;
            capture_done <= 1'b1;
            hit          <= 1'b0;
            miss_cnt     <= 4'd0;
          end
          TRACK: begin
            if (accept) begin
              box_max_ready <= 1'b1;
              box_max_x     <= x_next;
              box_max_y     <= y_next;
              hit           <= 1'b1;
            end
            // A result arriving with frame_start belongs to the frame that is ending.
            if (frame_start) begin
              hit <= 1'b0;
              if (hit || accept)
                miss_cnt <= 4'd0;
              else if (miss_next >= LOST_CNT) begin
                st       <= MANUAL;
                lost     <= 1'b1;
                miss_cnt <= 4'd0;
              end else
                miss_cnt <= miss_next;
            end
          end
          default: st <= MANUAL;
        endcase
      end
    end
  end

endmodule
